// File: rtl/polyvec_matrix_pointwise_montgomery.sv
// Coefficient-serial NTT-domain matrix-vector product t = A*v with Montgomery reduction.
// Define POLYVEC_MATVEC_FINAL_REDUCE_EN to apply reduce32 on the last column accumulate.
module polyvec_matrix_pointwise_montgomery #(
    parameter int K    = 6,
    parameter int L    = 5,
    parameter int N    = 256,
    parameter int Q    = 8380417,
    parameter int QINV = 58728449
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [65535:0] mat1,
    input  logic [65535:0] mat2,
    input  logic [65535:0] mat3,
    input  logic [49151:0] mat4,
    input  logic [40959:0] v_in,
    output logic [49151:0] t_out,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_next;
    logic        drain_second;
    logic        issue, done_next, last_issue;
    logic [2:0]  ci, cj;
    logic [7:0]  cn;

    logic [245759:0] mat_all;
    logic [4:0]      p;
    logic [17:0]     a_idx;
    logic [15:0]     v_idx;

    logic               op_valid;
    logic signed [31:0] op_a, op_v;
    logic [2:0]         op_i, op_j;
    logic [7:0]         op_n;
    logic signed [63:0] a_ext, v_ext;

    logic               s1_valid;
    logic signed [63:0] s1_prod;
    logic [2:0]         s1_i, s1_j;
    logic [7:0]         s1_n;

    logic [31:0]        lo_x_qinv;
    logic signed [31:0] m;
    logic signed [63:0] mq, diff;
    logic signed [31:0] r;
    logic [15:0]        t_idx;
    logic signed [31:0] acc_old, acc_sum, acc_new;

    // Polynomial p = i*L + j lives at p*8192 within the concatenated matrix buses.
    assign mat_all    = {mat4, mat3, mat2, mat1};
    assign p          = 5'(ci) * 5'(L) + 5'(cj);
    assign a_idx      = {p, cn, 5'b0};
    assign v_idx      = {cj, cn, 5'b0};
    assign last_issue = (ci == 3'(K - 1)) && (cj == 3'(L - 1)) && (cn == 8'(N - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            drain_second <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            drain_second <= (state == DRAIN) && !drain_second;
            done         <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (drain_second) state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue     = (state == RUN);
        done_next = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset || state != RUN) begin
            ci <= '0;
            cj <= '0;
            cn <= '0;
        end else begin
            cn <= cn + 8'd1;
            if (cn == 8'(N - 1)) begin
                if (cj == 3'(L - 1)) begin
                    cj <= '0;
                    ci <= ci + 3'd1;
                end else begin
                    cj <= cj + 3'd1;
                end
            end
        end
    end

    // Operands are registered before the multiplier to isolate the wide selection mux.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_valid <= 1'b0;
        end else begin
            op_valid <= issue;
        end
        op_a <= mat_all[a_idx +: 32];
        op_v <= v_in[v_idx +: 32];
        op_i <= ci;
        op_j <= cj;
        op_n <= cn;
    end

    assign a_ext = {{32{op_a[31]}}, op_a};
    assign v_ext = {{32{op_v[31]}}, op_v};

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= op_valid;
        end
        s1_prod <= a_ext * v_ext;
        s1_i    <= op_i;
        s1_j    <= op_j;
        s1_n    <= op_n;
    end

    // The low word of prod - m*Q is zero by construction, so r is just the high word.
    assign lo_x_qinv = s1_prod[31:0] * 32'(QINV);
    assign m         = lo_x_qinv;
    assign mq        = {{32{m[31]}}, m} * 64'(Q);
    assign diff      = s1_prod - mq;
    assign r         = 32'(diff >>> 32);

    assign t_idx   = {s1_i, s1_n, 5'b0};
    assign acc_old = t_out[t_idx +: 32];
    assign acc_sum = acc_old + r;

`ifdef POLYVEC_MATVEC_FINAL_REDUCE_EN
    logic signed [31:0] red_t, acc_reduced;
    assign red_t       = (acc_sum + 32'sd4194304) >>> 23;
    assign acc_reduced = acc_sum - red_t * 32'(Q);

    always_comb begin
        acc_new = acc_sum;
        if (s1_j == 3'd0) begin
            acc_new = r;
        end else if (s1_j == 3'(L - 1)) begin
            acc_new = acc_reduced;
        end
    end
`else
    always_comb begin
        acc_new = acc_sum;
        if (s1_j == 3'd0) begin
            acc_new = r;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            t_out <= '0;
        end else if (s1_valid) begin
            t_out[t_idx +: 32] <= acc_new;
        end
    end

endmodule

// File: tb/tb_polyvec_matrix_pointwise_montgomery.sv
// Scoreboard bench for polyvec_matrix_pointwise_montgomery; expectations follow from
// A = k*(2^32 mod Q), which makes each Montgomery term equal to k*v exactly.
`timescale 1ns/1ps
module tb_polyvec_matrix_pointwise_montgomery;

    localparam int R_MONT  = 4193792;
    localparam int QMOD    = 8380417;
    localparam int LATENCY = 7683;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [245759:0] mat_all = '0;
    logic [40959:0]  v_in = '0;
    logic [65535:0]  mat1, mat2, mat3;
    logic [49151:0]  mat4;
    logic [49151:0]  t_out;
    logic            done;

    typedef struct {
        logic [49151:0] t;
        int             done_cycle;
        bit             one_shot;
        int             id;
    } exp_t;

    exp_t           sb[$];
    logic [49151:0] exp_vec = '0;
    int             n_checks = 0;
    int             n_fail = 0;
    int             cycle = 0;

    assign mat1 = mat_all[65535:0];
    assign mat2 = mat_all[131071:65536];
    assign mat3 = mat_all[196607:131072];
    assign mat4 = mat_all[245759:196608];

    polyvec_matrix_pointwise_montgomery dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .mat1  (mat1),
        .mat2  (mat2),
        .mat3  (mat3),
        .mat4  (mat4),
        .v_in  (v_in),
        .t_out (t_out),
        .done  (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic int final_fix(input int x);
`ifdef POLYVEC_MATVEC_FINAL_REDUCE_EN
        return x - ((x + 4194304) >>> 23) * QMOD;
`else
        return x;
`endif
    endfunction

    function automatic int count_nonzero(input logic [49151:0] x);
        int c = 0;
        for (int k = 0; k < 1536; k++) if (x[k*32 +: 32] != 32'd0) c++;
        return c;
    endfunction

    task automatic set_a(input int i, input int j, input int n, input int val);
        mat_all[((i*5 + j)*8192 + n*32) +: 32] = val;
    endtask

    task automatic set_v(input int j, input int n, input int val);
        v_in[(j*8192 + n*32) +: 32] = val;
    endtask

    task automatic set_t(input int i, input int n, input int val);
        exp_vec[(i*8192 + n*32) +: 32] = val;
    endtask

    task automatic clear_all();
        mat_all = '0;
        v_in    = '0;
        exp_vec = '0;
    endtask

    task automatic checkOutput(input string what, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", what, got, want);
        end
    endtask

    // Push the expected result, start the block, and wait (bounded) for done.
    task automatic applyStimulus(input int id, input bit hold);
        exp_t e;
        int   waited;
        e.t          = exp_vec;
        e.done_cycle = cycle + 1 + LATENCY;
        e.one_shot   = !hold;
        e.id         = id;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clock);
        if (!hold) begin
            repeat (20) @(negedge clock);
            start = 1'b0;
        end
        waited = 0;
        while (!done && waited < LATENCY + 50) begin
            @(negedge clock);
            waited++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL run%0d done_timeout: got done=0 after %0d cycles, want done=1", id, waited);
        end
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clock);
                checkOutput("done_held", int'(done), 1);
            end
            start = 1'b0;
            repeat (2) @(negedge clock);
            checkOutput("done_fall", int'(done), 0);
        end else begin
            repeat (2) @(negedge clock);
        end
        start = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic done_q;
        done_q = 1'b0;
        forever begin
            @(negedge clock);
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, want no done", cycle);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("run%0d done_cycle", e.id), cycle, e.done_cycle);
                    for (int i = 0; i < 6; i++) begin
                        int bad = 0;
                        int first = -1;
                        int got_v = 0;
                        int want_v = 0;
                        for (int n = 0; n < 256; n++) begin
                            if (t_out[(i*8192 + n*32) +: 32] != e.t[(i*8192 + n*32) +: 32]) begin
                                if (first < 0) begin
                                    first  = n;
                                    got_v  = t_out[(i*8192 + n*32) +: 32];
                                    want_v = e.t[(i*8192 + n*32) +: 32];
                                end
                                bad++;
                            end
                        end
                        n_checks++;
                        if (bad != 0) begin
                            n_fail++;
                            $display("[TB] FAIL run%0d t_row%0d: %0d coeffs differ, first n=%0d got %0d want %0d",
                                     e.id, i, bad, first, got_v, want_v);
                        end
                    end
                    if (e.one_shot) begin
                        @(negedge clock);
                        checkOutput($sformatf("run%0d done_width", e.id), int'(done), 0);
                    end
                end
            end
            done_q = done;
        end
    end

    // Row i gets A = s_j*(i+1)*R with s_1 = +1 and -1 elsewhere; v[j][n] = n+1+7j.
    task automatic load_signed_pattern();
        clear_all();
        for (int i = 0; i < 6; i++) begin
            for (int n = 0; n < 256; n++) begin
                int sum = 0;
                for (int j = 0; j < 5; j++) begin
                    int s = (j == 1) ? 1 : -1;
                    set_a(i, j, n, s * (i + 1) * R_MONT);
                    sum += s * (i + 1) * (n + 1 + 7*j);
                end
                set_t(i, n, final_fix(sum));
            end
        end
        for (int j = 0; j < 5; j++)
            for (int n = 0; n < 256; n++) set_v(j, n, n + 1 + 7*j);
    endtask

    initial begin : stimulus
        repeat (3) @(negedge clock);
        checkOutput("reset_t_out_nonzero", count_nonzero(t_out), 0);
        checkOutput("reset_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] run1: A=0, random v, start held");
        clear_all();
        for (int j = 0; j < 5; j++)
            for (int n = 0; n < 256; n++) set_v(j, n, int'($urandom));
        applyStimulus(1, 1'b1);

        $display("[TB] run2: A=R everywhere, v=1, start dropped in RUN");
        clear_all();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5; j++)
                for (int n = 0; n < 256; n++) set_a(i, j, n, R_MONT);
        for (int j = 0; j < 5; j++)
            for (int n = 0; n < 256; n++) set_v(j, n, 1);
        for (int i = 0; i < 6; i++)
            for (int n = 0; n < 256; n++) set_t(i, n, final_fix(5));
        applyStimulus(2, 1'b0);

        $display("[TB] run3: single term A[2][3][7]");
        clear_all();
        set_a(2, 3, 7, R_MONT);
        set_v(3, 7, 1);
        set_t(2, 7, final_fix(1));
        applyStimulus(3, 1'b0);

        $display("[TB] run4: signed per-row pattern");
        load_signed_pattern();
        applyStimulus(4, 1'b1);

        $display("[TB] run5: large sums, v=1000000");
        clear_all();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5; j++)
                for (int n = 0; n < 256; n++) set_a(i, j, n, R_MONT);
        for (int j = 0; j < 5; j++)
            for (int n = 0; n < 256; n++) set_v(j, n, 1000000);
        for (int i = 0; i < 6; i++)
            for (int n = 0; n < 256; n++) set_t(i, n, final_fix(5000000));
        applyStimulus(5, 1'b0);

        $display("[TB] run6: reset mid-RUN, then restart");
        load_signed_pattern();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3000) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midrun_reset_t_out_nonzero", count_nonzero(t_out), 0);
        checkOutput("midrun_reset_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(6, 1'b0);

        repeat (4) @(negedge clock);
        checkOutput("scoreboard_left", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
